sc_velocity_ctrl: RTL and testbench
===================================

SC_VELOCITY_CTRL -- requirements
Module: sc_velocity_ctrl

Interface
REQ-001 HOLDOFF_CYCLES, default 16, crash holdoff length in clock cycles, minimum 2.
REQ-002 HOLDOFF_WIDTH, default 5, holdoff counter width; SHALL satisfy 2^HOLDOFF_WIDTH > HOLDOFF_CYCLES.
REQ-003 SC_VELCTRL_CLOCK_50  input  1  the only clock; all state changes on its rising edge.
REQ-004 SC_VELCTRL_RESET_InHigh  input  1  reset, asynchronous and active-high.
REQ-005 SC_VELCTRL_eoc_InLow  input  3  end-of-count ticks from the three velocity counters; bit0=level 1 (slowest), bit2=level 3; active-low, one cycle wide.
REQ-006 SC_VELCTRL_speedUp_InLow  input  1  accelerate button, active-low level, already debounced.
REQ-007 SC_VELCTRL_speedDown_InLow  input  1  decelerate button, active-low level, already debounced.
REQ-008 SC_VELCTRL_crash_InLow  input  1  collision indication, active-low level.
REQ-009 SC_VELCTRL_count_OutLow  output  3  per-counter count enable; 0 = counter counts, 1 = counter held cleared.
REQ-010 SC_VELCTRL_step_OutHigh  output  1  one-cycle movement step pulse.
REQ-011 SC_VELCTRL_level_Out  output  2  current speed level, 0 = stopped, 1..3 = running.

Function
REQ-012 FSM states SHALL be STOP, FLUSH, RUN, CRASH; all outputs SHALL be registered.
REQ-013 Button presses SHALL be detected on the 1->0 transition of the registered button sample; held buttons SHALL produce exactly one event.
REQ-014 Up event in STOP: level 0->1, go FLUSH.
REQ-015 Up event in RUN at level 1 or 2: level+1, go FLUSH; at level 3: no change, no FLUSH (saturate).
REQ-016 Down event in RUN at level 2 or 3: level-1, go FLUSH; at level 1: level 0, go STOP; down in STOP ignored.
REQ-017 Up and down events in the same cycle SHALL both be discarded.
REQ-018 FLUSH SHALL last exactly one cycle with count_OutLow=3'b111, then go RUN.
REQ-019 In RUN, count_OutLow SHALL be 0 only on the bit selected by level (level 1 -> 3'b110, 2 -> 3'b101, 3 -> 3'b011); in STOP and CRASH it SHALL be 3'b111.
REQ-020 Latency: event sampled in cycle N -> FLUSH and new level_Out visible in N+1 -> RUN count_OutLow visible in N+2.
REQ-021 In RUN, eoc_InLow low on the selected bit in cycle N SHALL give step_OutHigh=1 in N+1 only; eoc on non-selected bits, and any eoc in STOP/FLUSH/CRASH, SHALL be ignored.
REQ-022 crash_InLow low in any state SHALL, on the next edge, force CRASH, level 0, step 0; crash has priority over buttons and eoc in the same cycle.
REQ-023 CRASH SHALL hold for HOLDOFF_CYCLES cycles counted after crash_InLow returns high; crash reasserted during holdoff SHALL restart the count from 0.
REQ-024 On holdoff expiry, CRASH SHALL go STOP; button events during CRASH SHALL be discarded, not queued.
REQ-025 Holdoff counter SHALL be HOLDOFF_WIDTH bits and SHALL NOT wrap; it stops at HOLDOFF_CYCLES-1.

Reset
REQ-026 While reset is high: state STOP, level_Out=0, count_OutLow=3'b111, step_OutHigh=0, holdoff=0, button sample registers=1 (released).
REQ-027 A button held low through reset deassertion SHALL NOT produce an event.
REQ-028 Reset mid-FLUSH, mid-RUN or mid-CRASH SHALL abort immediately to the REQ-026 values.

Structure
REQ-029 Shared package SHALL hold the state encoding (STOP/FLUSH/RUN/CRASH) and level constants (LEVEL_STOP, LEVEL_MAX=3).
REQ-030 One sub-module sc_edge_detect_low (registered active-low falling-edge detector, same clock/reset) SHALL be instantiated twice, for speedUp and speedDown.

Verification
REQ-031 Reset, then one up press -> level_Out 1 at N+1, count_OutLow 3'b111 at N+1, 3'b110 at N+2; eoc_InLow=3'b110 for one cycle -> one step pulse on the next cycle.
REQ-032 Four up presses from STOP -> levels 1,2,3,3; the fourth produces no FLUSH cycle; count_OutLow settles at 3'b011.
REQ-033 Level 2 running, eoc_InLow=3'b110 and 3'b011 pulses -> no step; 3'b101 -> exactly one step.
REQ-034 Up and down falling in the same cycle at level 2 -> level stays 2, no FLUSH.
REQ-035 Level 3, crash low 3 cycles, released, up pressed during holdoff -> CRASH, level 0, count_OutLow 3'b111; STOP exactly 16 cycles after release; level stays 0.
REQ-036 Reset asserted during FLUSH with up button held low -> REQ-026 values; after release no level change until the button is released and pressed again.

Source files
------------

// File: rtl/sc_velocity_ctrl_pkg.sv
// Shared definitions for the velocity controller.
//   vel_state_e  : controller state encoding (STOP, FLUSH, RUN, CRASH)
//   LEVEL_*      : speed level constants (0 = stopped, 1..3 = running)
//   count_mask() : maps a speed level to its active-low counter enable pattern
package sc_velocity_ctrl_pkg;

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        FLUSH = 2'd1,
        RUN   = 2'd2,
        CRASH = 2'd3
    } vel_state_e;

    localparam logic [1:0] LEVEL_STOP = 2'd0;
    localparam logic [1:0] LEVEL_MIN  = 2'd1;
    localparam logic [1:0] LEVEL_MAX  = 2'd3;

    // All three velocity counters held cleared.
    localparam logic [2:0] COUNT_ALL_HELD = 3'b111;

    // Only the counter belonging to the current level is released (driven 0).
    function automatic logic [2:0] count_mask(input logic [1:0] level);
        logic [2:0] mask;
        case (level)
            2'd1:    mask = 3'b110;
            2'd2:    mask = 3'b101;
            2'd3:    mask = 3'b011;
            default: mask = COUNT_ALL_HELD;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/sc_edge_detect_low.sv
// Registered falling-edge detector for an active-low, already debounced button.
//   clk        : clock
//   rst        : asynchronous active-high reset
//   btn_in_low : button level, 0 = pressed
//   fall_out   : one-cycle registered pulse after the sample goes 1 -> 0
// The sample register resets to 1 (released). The first edge after reset only
// loads the sample, so a button held through reset never produces an event.
module sc_edge_detect_low (
    input  logic clk,
    input  logic rst,
    input  logic btn_in_low,
    output logic fall_out
);

    logic samp_q;
    logic samp_d;
    logic armed_q;
    logic armed_d;
    logic fall_q;
    logic fall_d;

    always_comb begin
        samp_d  = btn_in_low;
        armed_d = 1'b1;
        fall_d  = armed_q & samp_q & ~btn_in_low;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_q  <= 1'b1;
            armed_q <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            samp_q  <= samp_d;
            armed_q <= armed_d;
            fall_q  <= fall_d;
        end
    end

    assign fall_out = fall_q;

endmodule

// File: rtl/sc_velocity_ctrl.sv
// Velocity controller: selects one of three velocity counters from the speed
// level set by the up/down buttons, turns that counter's end-of-count tick into
// a movement step pulse, and freezes everything for a holdoff after a crash.
//   SC_VELCTRL_CLOCK_50        : clock
//   SC_VELCTRL_RESET_InHigh    : asynchronous active-high reset
//   SC_VELCTRL_eoc_InLow[2:0]  : end-of-count ticks, bit0 = level 1, active-low
//   SC_VELCTRL_speedUp_InLow   : accelerate button, active-low level
//   SC_VELCTRL_speedDown_InLow : decelerate button, active-low level
//   SC_VELCTRL_crash_InLow     : collision indication, active-low level
//   SC_VELCTRL_count_OutLow    : per-counter enable, 0 = count, 1 = held cleared
//   SC_VELCTRL_step_OutHigh    : one-cycle step pulse
//   SC_VELCTRL_level_Out       : speed level, 0 = stopped
// HOLDOFF_CYCLES must be at least 2 and below 2**HOLDOFF_WIDTH.
module sc_velocity_ctrl
    import sc_velocity_ctrl_pkg::*;
#(
    parameter int HOLDOFF_CYCLES = 16,
    parameter int HOLDOFF_WIDTH  = 5
) (
    input  logic       SC_VELCTRL_CLOCK_50,
    input  logic       SC_VELCTRL_RESET_InHigh,
    input  logic [2:0] SC_VELCTRL_eoc_InLow,
    input  logic       SC_VELCTRL_speedUp_InLow,
    input  logic       SC_VELCTRL_speedDown_InLow,
    input  logic       SC_VELCTRL_crash_InLow,
    output logic [2:0] SC_VELCTRL_count_OutLow,
    output logic       SC_VELCTRL_step_OutHigh,
    output logic [1:0] SC_VELCTRL_level_Out
);

    localparam logic [HOLDOFF_WIDTH-1:0] HOLD_LAST = HOLDOFF_WIDTH'(HOLDOFF_CYCLES - 1);
    localparam logic [HOLDOFF_WIDTH-1:0] HOLD_ONE  = HOLDOFF_WIDTH'(1);

    logic clk;
    logic rst;

    assign clk = SC_VELCTRL_CLOCK_50;
    assign rst = SC_VELCTRL_RESET_InHigh;

    logic up_fall;
    logic down_fall;
    logic up_evt;
    logic down_evt;
    logic eoc_hit;

    vel_state_e             state_q;
    vel_state_e             state_d;
    logic [1:0]             level_q;
    logic [1:0]             level_d;
    logic [2:0]             count_q;
    logic [2:0]             count_d;
    logic                   step_q;
    logic                   step_d;
    logic [HOLDOFF_WIDTH-1:0] hold_q;
    logic [HOLDOFF_WIDTH-1:0] hold_d;

    sc_edge_detect_low u_up_edge (
        .clk        (clk),
        .rst        (rst),
        .btn_in_low (SC_VELCTRL_speedUp_InLow),
        .fall_out   (up_fall)
    );

    sc_edge_detect_low u_down_edge (
        .clk        (clk),
        .rst        (rst),
        .btn_in_low (SC_VELCTRL_speedDown_InLow),
        .fall_out   (down_fall)
    );

    // Simultaneous up and down cancel each other.
    assign up_evt   = up_fall & ~down_fall;
    assign down_evt = down_fall & ~up_fall;

    // A tick counts only on the counter currently released for this level.
    assign eoc_hit = |(~SC_VELCTRL_eoc_InLow & ~count_mask(level_q));

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        hold_d  = hold_q;
        step_d  = 1'b0;

        if (!SC_VELCTRL_crash_InLow) begin
            // Crash overrides buttons and ticks; holdoff restarts while held.
            state_d = CRASH;
            level_d = LEVEL_STOP;
            hold_d  = '0;
        end else begin
            case (state_q)
                STOP: begin
                    if (up_evt) begin
                        level_d = LEVEL_MIN;
                        state_d = FLUSH;
                    end
                end
                FLUSH: begin
                    // Button events landing in the flush cycle are dropped.
                    state_d = RUN;
                end
                RUN: begin
                    step_d = eoc_hit;
                    if (up_evt && (level_q != LEVEL_MAX)) begin
                        level_d = level_q + 2'd1;
                        state_d = FLUSH;
                    end else if (down_evt) begin
                        level_d = level_q - 2'd1;
                        state_d = (level_q == LEVEL_MIN) ? STOP : FLUSH;
                    end
                end
                CRASH: begin
                    // Counter saturates at HOLD_LAST; leaving CRASH clears it.
                    if (hold_q == HOLD_LAST) begin
                        state_d = STOP;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + HOLD_ONE;
                    end
                end
                default: begin
                    state_d = STOP;
                    level_d = LEVEL_STOP;
                end
            endcase
        end

        // Outputs are registered from the next state so they line up with it.
        count_d = (state_d == RUN) ? count_mask(level_d) : COUNT_ALL_HELD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= STOP;
            level_q <= LEVEL_STOP;
            count_q <= COUNT_ALL_HELD;
            step_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            count_q <= count_d;
            step_q  <= step_d;
            hold_q  <= hold_d;
        end
    end

    assign SC_VELCTRL_count_OutLow = count_q;
    assign SC_VELCTRL_step_OutHigh = step_q;
    assign SC_VELCTRL_level_Out    = level_q;

endmodule

// File: tb/tb_sc_velocity_ctrl.sv
module tb_sc_velocity_ctrl;

    localparam int HC = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       up_in = 1'b1;
    logic       dn_in = 1'b1;
    logic       cr_in = 1'b1;
    logic [2:0] eoc_in = 3'b111;
    logic [2:0] count_out;
    logic       step_out;
    logic [1:0] level_out;

    int n_checks = 0;
    int n_errors = 0;

    sc_velocity_ctrl #(.HOLDOFF_CYCLES(HC), .HOLDOFF_WIDTH(5)) dut (
        .SC_VELCTRL_CLOCK_50        (clk),
        .SC_VELCTRL_RESET_InHigh    (rst),
        .SC_VELCTRL_eoc_InLow       (eoc_in),
        .SC_VELCTRL_speedUp_InLow   (up_in),
        .SC_VELCTRL_speedDown_InLow (dn_in),
        .SC_VELCTRL_crash_InLow     (cr_in),
        .SC_VELCTRL_count_OutLow    (count_out),
        .SC_VELCTRL_step_OutHigh    (step_out),
        .SC_VELCTRL_level_Out       (level_out)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (spec rules, plain integers) ----------
    localparam int M_STOP = 0, M_FLUSH = 1, M_RUN = 2, M_CRASH = 3;
    int m_mode, m_level, m_step, m_since, m_post;
    int uh1, uh2, dh1, dh2;
    logic [2:0] mask_tbl [4] = '{3'b111, 3'b110, 3'b101, 3'b011};

    task automatic model_reset();
        m_mode = M_STOP; m_level = 0; m_step = 0; m_since = 0; m_post = 0;
        uh1 = 1; uh2 = 1; dh1 = 1; dh2 = 1;
    endtask

    task automatic model_edge();
        bit ue, de, u_ok, d_ok;
        ue = (m_post >= 2) && (uh2 == 1) && (uh1 == 0);
        de = (m_post >= 2) && (dh2 == 1) && (dh1 == 0);
        u_ok = ue && !de;
        d_ok = de && !ue;
        m_step = 0;
        if (cr_in == 1'b0) begin
            m_mode = M_CRASH; m_level = 0; m_since = 0;
        end else if (m_mode == M_STOP) begin
            if (u_ok) begin m_level = 1; m_mode = M_FLUSH; end
        end else if (m_mode == M_FLUSH) begin
            m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (((eoc_in >> (m_level - 1)) & 3'b001) == 3'b000) m_step = 1;
            if (u_ok && m_level < 3) begin
                m_level++; m_mode = M_FLUSH;
            end else if (d_ok) begin
                m_level--; m_mode = (m_level == 0) ? M_STOP : M_FLUSH;
            end
        end else begin
            m_since++;
            if (m_since == HC) m_mode = M_STOP;
        end
        uh2 = uh1; uh1 = int'(up_in);
        dh2 = dh1; dh1 = int'(dn_in);
        if (m_post < 2) m_post++;
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [1:0] lvl, input logic [2:0] cnt, input logic stp);
        n_checks++;
        if (level_out !== lvl || count_out !== cnt || step_out !== stp) begin
            n_errors++;
            $display("FAIL %s @%0t: got level=%0d count=%b step=%b, want level=%0d count=%b step=%b",
                     name, $time, level_out, count_out, step_out, lvl, cnt, stp);
        end
    endtask

    task automatic chk_model(input string name);
        chk(name, 2'(m_level), (m_mode == M_RUN) ? mask_tbl[m_level] : 3'b111, 1'(m_step));
    endtask

    task automatic tick(input logic u, input logic d, input logic c, input logic [2:0] e);
        up_in = u; dn_in = d; cr_in = c; eoc_in = e;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Called at posedge+1; asserts reset asynchronously, checks, releases.
    task automatic do_reset(input string name);
        rst = 1'b1;
        model_reset();
        #1;
        chk(name, 2'd0, 3'b111, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic press_up();
        tick(1'b0, 1'b1, 1'b1, 3'b111);
        tick(1'b1, 1'b1, 1'b1, 3'b111);
        tick(1'b1, 1'b1, 1'b1, 3'b111);
    endtask

    typedef struct {
        logic       up, dn, cr;
        logic [2:0] eoc;
        logic [1:0] lvl;
        logic [2:0] cnt;
        logic       stp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic u, input logic d, input logic c, input logic [2:0] e,
                                input logic [1:0] l, input logic [2:0] n, input logic s);
        vec_t v;
        v.up = u; v.dn = d; v.cr = c; v.eoc = e; v.lvl = l; v.cnt = n; v.stp = s;
        return v;
    endfunction

    initial begin
        logic       up_v, dn_v, cr_v;
        logic [2:0] e_v;
        int         cr_len;

        // Row i: inputs held for one cycle, outputs expected after the edge.
        tbl.push_back(mk(1,1,1,3'b111, 0,3'b111,0)); // first edge after reset
        tbl.push_back(mk(0,1,1,3'b111, 0,3'b111,0)); // up pressed, sampled
        tbl.push_back(mk(0,1,1,3'b111, 1,3'b111,0)); // FLUSH, level 1
        tbl.push_back(mk(1,1,1,3'b111, 1,3'b110,0)); // RUN level 1
        tbl.push_back(mk(1,1,1,3'b110, 1,3'b110,1)); // selected tick -> step
        tbl.push_back(mk(1,1,1,3'b111, 1,3'b110,0));
        tbl.push_back(mk(1,1,1,3'b101, 1,3'b110,0)); // non-selected tick
        tbl.push_back(mk(0,1,1,3'b111, 1,3'b110,0));
        tbl.push_back(mk(1,1,1,3'b111, 2,3'b111,0));
        tbl.push_back(mk(1,1,1,3'b111, 2,3'b101,0));
        tbl.push_back(mk(0,1,1,3'b111, 2,3'b101,0));
        tbl.push_back(mk(1,1,1,3'b111, 3,3'b111,0));
        tbl.push_back(mk(1,1,1,3'b111, 3,3'b011,0));
        tbl.push_back(mk(0,1,1,3'b111, 3,3'b011,0));
        tbl.push_back(mk(1,1,1,3'b111, 3,3'b011,0)); // saturated, no FLUSH
        tbl.push_back(mk(1,1,1,3'b111, 3,3'b011,0));
        tbl.push_back(mk(1,0,1,3'b111, 3,3'b011,0));
        tbl.push_back(mk(1,1,1,3'b111, 2,3'b111,0));
        tbl.push_back(mk(1,1,1,3'b111, 2,3'b101,0));
        tbl.push_back(mk(1,1,1,3'b110, 2,3'b101,0));
        tbl.push_back(mk(1,1,1,3'b011, 2,3'b101,0));
        tbl.push_back(mk(1,1,1,3'b101, 2,3'b101,1));
        tbl.push_back(mk(1,1,1,3'b111, 2,3'b101,0));
        tbl.push_back(mk(0,0,1,3'b111, 2,3'b101,0)); // up+down together
        tbl.push_back(mk(1,1,1,3'b111, 2,3'b101,0));
        tbl.push_back(mk(1,1,1,3'b111, 2,3'b101,0));
        tbl.push_back(mk(1,0,1,3'b111, 2,3'b101,0));
        tbl.push_back(mk(1,1,1,3'b111, 1,3'b111,0));
        tbl.push_back(mk(1,1,1,3'b111, 1,3'b110,0));
        tbl.push_back(mk(1,0,1,3'b111, 1,3'b110,0));
        tbl.push_back(mk(1,1,1,3'b111, 0,3'b111,0)); // level 1 down -> STOP
        tbl.push_back(mk(1,1,1,3'b111, 0,3'b111,0));
        tbl.push_back(mk(1,0,1,3'b111, 0,3'b111,0));
        tbl.push_back(mk(1,1,1,3'b111, 0,3'b111,0)); // down in STOP ignored
        tbl.push_back(mk(1,1,1,3'b110, 0,3'b111,0)); // tick in STOP ignored

        @(posedge clk);
        #1;
        do_reset("reset_values");
        foreach (tbl[i]) begin
            tick(tbl[i].up, tbl[i].dn, tbl[i].cr, tbl[i].eoc);
            chk($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].cnt, tbl[i].stp);
        end

        // Crash from level 3 with pending down event and selected tick.
        do_reset("reset_crash_seq");
        tick(1, 1, 1, 3'b111);
        press_up(); press_up(); press_up();
        chk("level3_run", 2'd3, 3'b011, 1'b0);
        tick(1, 0, 1, 3'b111);
        chk("pre_crash", 2'd3, 3'b011, 1'b0);
        tick(1, 1, 0, 3'b011);
        chk("crash_entry", 2'd0, 3'b111, 1'b0);
        tick(1, 1, 0, 3'b111);
        tick(1, 1, 0, 3'b111);
        chk("crash_held", 2'd0, 3'b111, 1'b0);
        // Presses during holdoff, the last landing in the final CRASH cycle.
        for (int k = 0; k < 31; k++) begin
            tick((k == 2 || k == 3 || k == 14) ? 1'b0 : 1'b1, 1, 1, 3'b111);
            chk($sformatf("holdoff_a%0d", k), 2'd0, 3'b111, 1'b0);
        end
        // Press whose event lands in the first STOP cycle is accepted.
        tick(1, 1, 0, 3'b111);
        for (int k = 0; k < 19; k++) begin
            tick((k == 15) ? 1'b0 : 1'b1, 1, 1, 3'b111);
            chk($sformatf("holdoff_b%0d", k),
                (k >= 16) ? 2'd1 : 2'd0, (k >= 17) ? 3'b110 : 3'b111, 1'b0);
        end

        // Reset during FLUSH with up held low through reset.
        do_reset("reset_flush_seq");
        tick(1, 1, 1, 3'b111);
        tick(0, 1, 1, 3'b111);
        tick(0, 1, 1, 3'b111);
        chk("in_flush", 2'd1, 3'b111, 1'b0);
        do_reset("reset_mid_flush");
        for (int k = 0; k < 5; k++) begin
            tick(0, 1, 1, 3'b111);
            chk($sformatf("held_after_reset%0d", k), 2'd0, 3'b111, 1'b0);
        end
        tick(1, 1, 1, 3'b111);
        tick(1, 1, 1, 3'b111);
        tick(0, 1, 1, 3'b111);
        chk("repress_sampled", 2'd0, 3'b111, 1'b0);
        tick(1, 1, 1, 3'b111);
        chk("repress_flush", 2'd1, 3'b111, 1'b0);
        tick(1, 1, 1, 3'b111);
        chk("repress_run", 2'd1, 3'b110, 1'b0);

        // Random stimulus against the model.
        do_reset("reset_random");
        up_v = 1; dn_v = 1; cr_v = 1; cr_len = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset("random_reset");
                continue;
            end
            if ($urandom_range(0, 5) == 0) up_v = ~up_v;
            if ($urandom_range(0, 5) == 0) dn_v = ~dn_v;
            if (cr_len > 0) begin
                cr_v = 0; cr_len--;
            end else if ($urandom_range(0, 79) == 0) begin
                cr_v = 0; cr_len = $urandom_range(0, 3);
            end else begin
                cr_v = 1;
            end
            e_v = 3'b111;
            if ($urandom_range(0, 2) == 0) e_v[$urandom_range(0, 2)] = 1'b0;
            tick(up_v, dn_v, cr_v, e_v);
            chk_model($sformatf("random%0d", cyc));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
